// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the RISC-V load/store funct3 codes and
// the access-legality check used at request acceptance.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // High when the request is misaligned or its funct3 has no meaning for
   // the given direction (unsigned variants exist only for loads).
   function automatic logic access_err(input logic [2:0] funct3,
                                       input logic [1:0] lane,
                                       input logic       write);
      logic err;
      err = 1'b1;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_H:    err = lane[0];
         F3_W:    err = (lane != 2'b00);
         F3_BU:   err = write;
         F3_HU:   err = write | lane[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for 32-bit little-endian memory words (combinational).
// Ports: funct3/lane select the access; wdata -> be/wlane for stores;
//        rword -> rext (sign/zero-extended load data, 0 for illegal funct3).
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] rext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

   // Store data is replicated across lanes so the byte enables alone pick
   // which bytes land in the word.
   always_comb begin
      be    = 4'b0000;
      wlane = wdata;
      case (funct3)
         F3_B: begin
            be    = 4'b0001 << lane;
            wlane = {4{wdata[7:0]}};
         end
         F3_H: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata[15:0]}};
         end
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      rext = '0;
      case (funct3)
         F3_B:    rext = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    rext = {{16{half_sel[15]}}, half_sel};
         F3_W:    rext = rword;
         F3_BU:   rext = {24'h000000, byte_sel};
         F3_HU:   rext = {16'h0000, half_sel};
         default: rext = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request per handshake, WAIT_CYCLES wait states,
// byte/half/word access on an internal word array, extended load data back.
// Ports: req_* (valid/ready request in), rsp_* (valid/ready response out);
//        latency accept->rsp_valid = WAIT_CYCLES+1 edges, errors respond at once;
//        req_ready only in IDLE, response held until rsp_ready.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DM_ADDRESS  = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   localparam int         DEPTH     = 2 ** (DM_ADDRESS - 2);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

   state_t                  state, state_nxt;
   logic                    r_write;
   logic [2:0]              r_funct3;
   logic [DM_ADDRESS-1:0]   r_addr;
   logic [DATA_W-1:0]       r_wdata;
   logic [3:0]              cnt;
   logic [DATA_W-1:0]       mem [DEPTH];

   logic                    accept;
   logic                    req_err;
   logic [DM_ADDRESS-3:0]   widx;
   logic [DATA_W-1:0]       rword;
   logic [3:0]              be;
   logic [DATA_W-1:0]       wlane;
   logic [DATA_W-1:0]       rext;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid & req_ready;
   assign req_err   = access_err(req_funct3, req_addr[1:0], req_write);
   assign widx      = r_addr[DM_ADDRESS-1:2];
   assign rword     = mem[widx];

   dmem_lane_align u_align (
      .funct3 (r_funct3),
      .lane   (r_addr[1:0]),
      .wdata  (r_wdata),
      .rword  (rword),
      .be     (be),
      .wlane  (wlane),
      .rext   (rext)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)              state_nxt = RESP;
               else if (WAIT_CYCLES > 0) state_nxt = WAIT;
               else                      state_nxt = ACCESS;
            end
         end
         WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_write   <= 1'b0;
         r_funct3  <= 3'b000;
         r_addr    <= '0;
         r_wdata   <= '0;
         cnt       <= 4'd0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  r_write   <= req_write;
                  r_funct3  <= req_funct3;
                  r_addr    <= req_addr;
                  r_wdata   <= req_wdata;
                  cnt       <= WAIT_INIT;
                  rsp_err   <= req_err;
                  rsp_rdata <= '0;
               end
            end
            WAIT:   if (cnt != 4'd0) cnt <= cnt - 4'd1;
            ACCESS: rsp_rdata <= r_write ? '0 : rext;
            RESP: begin
               if (rsp_ready) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage is not reset. Reset forces state to IDLE asynchronously, so a
   // store still waiting for its ACCESS edge never commits.
   always_ff @(posedge clk) begin
      if (state == ACCESS && r_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

endmodule
